// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package rr_arbiter4_pkg;

  // Arbiter FSM states
  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  // Reset value of the last-owner pointer; makes the first search start at index 0
  localparam logic [1:0] LastRst = 2'b11;

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;

  modport master (output req, output done, input gnt, input gnt_idx, input busy);
  modport slave  (input req, input done, output gnt, output gnt_idx, output busy);
endinterface

// File: rtl/rr_arbiter4_dec2to4_en.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module dec2to4_en (
  input  logic [1:0] in_i,
  input  logic       en_i,
  output logic [3:0] out_o
);

  // Decode the binary index into a one-hot vector, gated by enable
  always_comb begin
    out_o = 4'b0000;
    if (en_i) begin
      out_o[in_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter. The last owner gets lowest priority on
// the next search; the grant index is registered and decoded to a one-hot gnt.
// Optional forced release after MAX_HOLD cycles is enabled with `define RR_TIMEOUT_EN.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter4_if.slave bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 15 || (32'd1 << CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_arbiter4: illegal MAX_HOLD/CNT_W combination");
  end

  // Returns {found, index}; scans last+1, last+2, last+3, last (mod 4)
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!res[2] && req[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] last_q, last_d;
  logic [2:0] pick_idle, pick_rel;
  logic       rel;
  logic       timeout;

`ifdef RR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             others_req;
  logic             new_grant;

  // Forced release once the owner has held MAX_HOLD cycles and someone else waits
  always_comb begin
    others_req = |(bus.req & ~(4'b0001 << idx_q));
    timeout    = (state_q == StGrant) && (cnt_q == HoldLast) && others_req;
  end

  // Hold counter: clears on every new grant, saturates at MAX_HOLD-1
  always_comb begin
    new_grant = (state_d == StGrant) && ((state_q == StIdle) || rel);
    cnt_d     = cnt_q;
    if (new_grant) begin
      cnt_d = '0;
    end else if (state_q == StGrant && cnt_q != HoldLast) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Hold counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Release detection and the two candidate winners (from idle, and on handover)
  always_comb begin
    rel       = (state_q == StGrant) && (bus.done || !bus.req[idx_q] || timeout);
    pick_idle = rr_pick(bus.req, last_q);
    pick_rel  = rr_pick(bus.req, idx_q);
  end

  // State register: all arbiter state drops immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 2'b00;
      last_q  <= LastRst;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // Next-state: grant from idle, or hand over / re-grant / go idle on release
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (pick_idle[2]) begin
          state_d = StGrant;
          idx_d   = pick_idle[1:0];
        end
      end
      StGrant: begin
        if (rel) begin
          last_d = idx_q;
          if (pick_rel[2]) begin
            idx_d = pick_rel[1:0];
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs come straight from registered state; gnt is decoded from index and busy
  always_comb begin
    bus.busy    = (state_q == StGrant);
    bus.gnt_idx = idx_q;
  end

  dec2to4_en u_dec (
    .in_i  (idx_q),
    .en_i  (state_q == StGrant),
    .out_o (bus.gnt)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed vector tables, hand-written
// reset/timeout sequences and randomized traffic against a behavioural model.
module tb_rr_arbiter4;

  localparam int MaxHold = 4;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] idx;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(
    .MAX_HOLD (MaxHold),
    .CNT_W    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: owner index (-1 = idle), last owner, cycles held so far
  int m_owner, m_last, m_held;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] gnt, input logic busy,
                           input logic [1:0] idx);
    check({name, " gnt"}, bus.gnt, gnt);
    check({name, " busy"}, {3'b000, bus.busy}, {3'b000, busy});
    if (busy) check({name, " idx"}, {2'b00, bus.gnt_idx}, {2'b00, idx});
  endtask

  // Invariant on every cycle out of reset
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_tests++;
      if (!$onehot0(bus.gnt) || bus.busy !== (|bus.gnt)) begin
        n_fail++;
        $display("FAIL invariant: gnt=%b busy=%b", bus.gnt, bus.busy);
      end
    end
  end

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    int  w;
    bit  forced;
    if (m_owner < 0) begin
      w = pick(r, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_held  = 1;
      end
    end else begin
      forced = 1'b0;
`ifdef RR_TIMEOUT_EN
      forced = (m_held >= MaxHold) && ((r & ~(4'b0001 << m_owner)) != 4'b0000);
`endif
      if (d || !r[m_owner] || forced) begin
        m_last  = m_owner;
        m_owner = pick(r, m_last);
        m_held  = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  // Drive inputs, clock once, sample 1 time unit after the edge
  task automatic tick(input logic [3:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    tick(v.req, v.done);
    check_out(name, v.gnt, v.busy, v.idx);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check_out("async rst", 4'b0000, 1'b0, 2'b00);
    #1 rst = 1'b0;
  endtask

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  initial begin
    logic [3:0] r;
    logic       d;
    logic [3:0] eg;

    tbl_a.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0});
    tbl_a.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0});
    tbl_a.push_back('{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0});
    tbl_a.push_back('{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0});
    tbl_a.push_back('{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1});

    tbl_b.push_back('{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0});
    tbl_b.push_back('{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0});
    tbl_b.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1});
    tbl_b.push_back('{4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1});
    tbl_b.push_back('{4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1});
    tbl_b.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2});
    tbl_b.push_back('{4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2});
    tbl_b.push_back('{4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2});
    tbl_b.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3});
    tbl_b.push_back('{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3});
    tbl_b.push_back('{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3});
    tbl_b.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0});
    tbl_b.push_back('{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2});
    tbl_b.push_back('{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2});
    tbl_b.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0});
    tbl_b.push_back('{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1});
    tbl_b.push_back('{4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1});
    tbl_b.push_back('{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3});
    tbl_b.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0});
    tbl_b.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0});

    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    #12;
    check_out("reset", 4'b0000, 1'b0, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl_a.size(); i++) apply_vec(tbl_a[i], $sformatf("tbl_a[%0d]", i));

    // Reset while owner 1 holds; last must return to 3 so 1111 picks 0 next
    pulse_reset();
    for (int i = 0; i < tbl_b.size(); i++) apply_vec(tbl_b[i], $sformatf("tbl_b[%0d]", i));

    pulse_reset();
`ifdef RR_TIMEOUT_EN
    for (int i = 0; i < MaxHold; i++) begin
      tick(4'b0011, 1'b0);
      check_out($sformatf("timeout hold %0d", i), 4'b0001, 1'b1, 2'd0);
    end
    tick(4'b0011, 1'b0);
    check_out("timeout rotate", 4'b0010, 1'b1, 2'd1);
    tick(4'b0001, 1'b0);
    check_out("timeout back to 0", 4'b0001, 1'b1, 2'd0);
    for (int i = 0; i < 3 * MaxHold; i++) begin
      tick(4'b0001, 1'b0);
      check_out($sformatf("sole owner %0d", i), 4'b0001, 1'b1, 2'd0);
    end
`else
    for (int i = 0; i < 3 * MaxHold; i++) begin
      tick(4'b0011, 1'b0);
      check_out($sformatf("no timeout hold %0d", i), 4'b0001, 1'b1, 2'd0);
    end
`endif

    // Randomized traffic against the model
    pulse_reset();
    model_reset();
    r = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 3) == 0);
      model_step(r, d);
      tick(r, d);
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      check_out($sformatf("rand %0d", c), eg, m_owner >= 0, 2'(m_owner));
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
        model_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource.
- The registered 2-bit grant index drives a 2-to-4 decoder, which produces the one-hot grant.
- Sits in front of any shared unit (bus, ALU, memory port) in the lab datapath and sequences ownership between requesters.
- Fair rotation: the last owner gets lowest priority on the next arbitration.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per owner before a forced release (used only with RR_TIMEOUT_EN); legal 2..15.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  4  request lines, req[i] from requester i, level-sensitive
- done  input  1  single-cycle pulse from the current owner releasing the resource
- gnt  output  4  one-hot grant, gnt[i] = requester i owns the resource; all-zero when idle
- gnt_idx  output  2  binary index of the current owner; valid only when busy=1
- busy  output  1  resource currently granted

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=4'b0000, gnt_idx=2'b00, busy=0, last=2'b11 (first search starts at 0), hold counter=0.
- Reset mid-grant: the grant drops in the same instant without waiting for a clock edge; the requester sees ownership lost.
- States:
  - IDLE: on an edge with req!=0, pick the winner, load gnt_idx, go to GRANT.
  - GRANT: the owner holds the resource.
- Winner search: scan indices last+1, last+2, last+3, last (mod 4); the first with req set wins. The previous owner is lowest priority.
- Latency: a req asserted before edge N gives gnt at edge N (one registered cycle). No combinational path from req to gnt.
- Release in GRANT occurs on an edge where any of these holds:
  - done=1
  - req[gnt_idx]=0 (requester withdrew)
  - forced timeout (optional feature)
- On release: last<=gnt_idx, then:
  - If any req is pending (including the old owner), grant the next winner on the same edge. This is back-to-back handover with no idle cycle.
  - If req is pending only from the old owner after done=1, it is re-granted.
  - If req==0, go to IDLE; gnt=0 and busy=0 from that edge.
- done while in IDLE is ignored.
- Simultaneous done and new requests: the handover uses req sampled on that same edge.
- req changes from non-owners during GRANT have no effect until release.
- gnt is always $onehot0; busy == |gnt.
- gnt is decoded from gnt_idx and busy, so it is glitch-free relative to the registered state.

Optional Feature:
- Macro: RR_TIMEOUT_EN.
- With the macro defined:
  - The hold counter clears on each new grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 and any other req bit is set, release is forced on that edge and the next winner is granted.
  - If no other requester is waiting, the counter saturates and the owner keeps the grant.
- Without the macro: no counter logic; the owner holds until done or its req drops.

Decomposition:
- Shared package/include file `rr_arb_defs.vh` holds:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
  - reset constant LAST_RST=2'b11
- One sub-module: `dec2to4_en`, a 2-to-4 decoder with enable (enable=busy), instantiated once to produce gnt from gnt_idx.
- The winner search is a combinational function inside rr_arbiter4.

Test Plan:
- Reset, then req=4'b0001 at cycle 2 -> gnt=4'b0001, gnt_idx=0, busy=1 at the next edge; rst pulse mid-grant -> gnt=0 immediately, last=3.
- req=4'b1111 held, done pulsed every 3 cycles -> grant order 0,1,2,3,0 with no idle cycles between owners.
- Owner 2 granted, req=4'b0100 only, done pulse -> gnt stays 4'b0100 (re-grant); then req drops to 0 -> IDLE, gnt=0, busy=0 on the next edge.
- Owner 1 granted, req[1] drops while req=4'b1000 -> gnt=4'b1000 on the same release edge; done asserted in IDLE -> no state change.
- RR_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011, no done -> grant rotates 0→1 after 4 cycles; with req=4'b0001 only, owner 0 is held indefinitely.
- Every cycle of all tests -> assert $onehot0(gnt) and busy==|gnt.
